// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit-arbiter FSM encoding, baud selector codes
// and default start timeout. Also used by uart_byte_tx and the benches.
package uart_pkg;

    // Transmit arbiter FSM states
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } tx_state_e;

    // baud_set encodings understood by uart_byte_tx
    localparam logic [2:0] BAUD_9600   = 3'd0;
    localparam logic [2:0] BAUD_19200  = 3'd1;
    localparam logic [2:0] BAUD_38400  = 3'd2;
    localparam logic [2:0] BAUD_57600  = 3'd3;
    localparam logic [2:0] BAUD_115200 = 3'd4;

    // Cycles allowed between send_en and uart_state rising
    localparam int unsigned DEFAULT_START_TIMEOUT = 16;

    // Bit rate for a baud_set code; unknown codes fall back to 9600
    function automatic int unsigned baud_rate(input logic [2:0] code);
        unique case (code)
            BAUD_9600:   baud_rate = 9600;
            BAUD_19200:  baud_rate = 19200;
            BAUD_38400:  baud_rate = 38400;
            BAUD_57600:  baud_rate = 57600;
            BAUD_115200: baud_rate = 115200;
            default:     baud_rate = 9600;
        endcase
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first asserted req searching upward from
// last_grant+1, wrapping modulo NUM_REQ.
module rr_arbiter #(
    parameter  int unsigned NUM_REQ = 2,
    localparam int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [IDX_W-1:0]   winner,
    output logic               valid
);

    // One extra bit so last_grant + offset never overflows before the wrap
    logic [IDX_W:0] idx;

    // Scan offsets 1..NUM_REQ; the first hit wins, so last_grant is checked last
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = '0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            idx = {1'b0, last_grant} + (IDX_W + 1)'(off);
            if (idx >= (IDX_W + 1)'(NUM_REQ)) begin
                idx = idx - (IDX_W + 1)'(NUM_REQ);
            end
            if (!valid && req[idx[IDX_W-1:0]]) begin
                valid  = 1'b1;
                winner = idx[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_byte_tx between NUM_REQ byte requesters. Latches the
// round-robin winner's byte, fires a single send_en, then follows
// uart_state/Tx_Done until the frame is out. Baud changes are held pending
// and only applied while idle.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter  int unsigned NUM_REQ       = 2,
    parameter  int unsigned START_TIMEOUT = DEFAULT_START_TIMEOUT,
    parameter  logic [2:0]  DEFAULT_BAUD  = BAUD_115200,
    localparam int unsigned IDX_W         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   ack,
    output logic [NUM_REQ-1:0]   done,
    input  logic [2:0]           cfg_baud,
    input  logic                 cfg_baud_wr,
    output logic [7:0]           data_byte,
    output logic                 send_en,
    output logic [2:0]           baud_set,
    input  logic                 Tx_Done,
    input  logic                 uart_state,
    output logic                 busy,
    output logic                 err_timeout,
    output logic [IDX_W-1:0]     last_grant
);

    localparam int unsigned CNT_W = $clog2(START_TIMEOUT + 1);

    tx_state_e            state_q, state_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;
    logic [NUM_REQ-1:0]   done_q, done_d;
    logic [7:0]           data_q, data_d;
    logic                 send_en_q, send_en_d;
    logic [2:0]           baud_q, baud_d;
    logic [2:0]           pend_q, pend_d;
    logic                 pend_valid_q, pend_valid_d;
    logic                 err_q, err_d;
    logic [IDX_W-1:0]     last_q, last_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic [IDX_W-1:0]     win;
    logic                 win_valid;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req        (req),
        .last_grant (last_q),
        .winner     (win),
        .valid      (win_valid)
    );

    // State and output registers; Rst aborts any transfer immediately
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q      <= IDLE;
            ack_q        <= '0;
            done_q       <= '0;
            data_q       <= '0;
            send_en_q    <= 1'b0;
            baud_q       <= DEFAULT_BAUD;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            err_q        <= 1'b0;
            last_q       <= IDX_W'(NUM_REQ - 1);
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            ack_q        <= ack_d;
            done_q       <= done_d;
            data_q       <= data_d;
            send_en_q    <= send_en_d;
            baud_q       <= baud_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            err_q        <= err_d;
            last_q       <= last_d;
            cnt_q        <= cnt_d;
        end
    end

    // Next-state logic; ack, done and send_en are single-cycle pulses
    always_comb begin
        state_d      = state_q;
        ack_d        = '0;
        done_d       = '0;
        send_en_d    = 1'b0;
        data_d       = data_q;
        baud_d       = baud_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        err_d        = err_q;
        last_d       = last_q;
        cnt_d        = cnt_q;

        unique case (state_q)
            IDLE: begin
                // Baud update and arbitration share this cycle
                if (pend_valid_q) begin
                    baud_d       = pend_q;
                    pend_valid_d = 1'b0;
                end
                if (win_valid) begin
                    data_d      = req_data[{win, 3'b000} +: 8];
                    ack_d[win]  = 1'b1;
                    last_d      = win;
                    state_d     = LAUNCH;
                end
            end
            LAUNCH: begin
                // send_en is registered, so it appears as WAIT_BUSY starts
                send_en_d = 1'b1;
                cnt_d     = '0;
                state_d   = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (uart_state) begin
                    state_d = WAIT_DONE;
                end else if (Tx_Done) begin
                    // Frame finished before uart_state was ever seen high
                    done_d[last_q] = 1'b1;
                    state_d        = IDLE;
                end else if (cnt_q == CNT_W'(START_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT_DONE: begin
                if (Tx_Done) begin
                    done_d[last_q] = 1'b1;
                    state_d        = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A write racing the idle apply becomes the next pending value
        if (cfg_baud_wr) begin
            pend_d       = cfg_baud;
            pend_valid_d = 1'b1;
        end
    end

    assign ack         = ack_q;
    assign done        = done_q;
    assign data_byte   = data_q;
    assign send_en     = send_en_q;
    assign baud_set    = baud_q;
    assign busy        = (state_q != IDLE);
    assign err_timeout = err_q;
    assign last_grant  = last_q;

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one uart_byte_tx serializer between NUM_REQ byte requesters using round-robin arbitration.
- Each requester uses a req/ack/done handshake. The block latches the winner's byte, issues a one-cycle send_en and tracks uart_state/Tx_Done until the byte is on the line.
- Owns the baud_set configuration and applies changes only between bytes.
- Sits between application logic (command responders, status reporters) and uart_byte_tx; the top level drives uart_byte_tx.Rst_n from ~Rst.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- START_TIMEOUT, 16, cycles allowed between send_en and uart_state rising before the byte is abandoned.
- DEFAULT_BAUD, 3'd4, baud_set value loaded at reset.

Ports:
- Clk  input  1  system clock; all logic on posedge.
- Rst  input  1  synchronous, active-high reset.
- req  input  NUM_REQ  per-requester byte request; held high with stable data until ack.
- req_data  input  8*NUM_REQ  byte for requester i at bits [8i+7:8i].
- ack  output  NUM_REQ  one-cycle pulse: requester i's byte latched; it may drop req or present the next byte.
- done  output  NUM_REQ  one-cycle pulse: requester i's byte has finished transmitting (Tx_Done seen).
- cfg_baud  input  3  requested baud_set.
- cfg_baud_wr  input  1  one-cycle strobe that captures cfg_baud into a pending register.
- data_byte  output  8  to uart_byte_tx.
- send_en  output  1  to uart_byte_tx; exactly one-cycle pulse per byte.
- baud_set  output  3  to uart_byte_tx.
- Tx_Done  input  1  from uart_byte_tx.
- uart_state  input  1  from uart_byte_tx; high while transmitting.
- busy  output  1  high in any state other than IDLE.
- err_timeout  output  1  sticky; set when START_TIMEOUT expires; cleared only by Rst.
- last_grant  output  clog2(NUM_REQ)  index of the most recently granted requester.

Behaviour:
- Reset values: ack=0, done=0, data_byte=0, send_en=0, baud_set=DEFAULT_BAUD, busy=0, err_timeout=0, last_grant=NUM_REQ-1 (so requester 0 wins first), FSM=IDLE, pending baud invalid. Rst mid-transfer aborts at once: no done pulse, send_en deasserts on the next cycle.
- FSM has four states: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - If the pending baud is valid, copy it to baud_set and clear pending. This takes one cycle, and arbitration proceeds in the same cycle.
  - If any req is high, pick the first set bit searching from last_grant+1 upward, modulo NUM_REQ.
  - Register data_byte=req_data[winner], pulse ack[winner], set last_grant=winner and go to LAUNCH.
  - Latency: req sampled high in IDLE -> ack in the next cycle -> send_en one cycle after ack.
- LAUNCH: send_en=1 for this single cycle; clear the timeout counter; go to WAIT_BUSY.
- WAIT_BUSY:
  - uart_state=1 -> WAIT_DONE.
  - Tx_Done=1 while still in WAIT_BUSY (very fast baud) -> treat as completion: pulse done[last_grant] and go to IDLE.
  - Counter reaches START_TIMEOUT -> set err_timeout, go to IDLE with no done pulse.
- WAIT_DONE: on Tx_Done=1, pulse done[last_grant] and go to IDLE. There is no timeout here, because frame length depends on baud.
- Arbitration:
  - A requester is never granted twice in a row while another requester is asserting req.
  - A lone requester may be granted back-to-back.
  - req dropped before ack is legal; that requester is simply not granted.
- Baud config:
  - cfg_baud_wr in any state updates the pending register; the last write wins.
  - baud_set never changes while busy=1.
  - A write in the same cycle as the IDLE apply is captured as the new pending value; the older value is the one applied that cycle.
- Minimum spacing: IDLE is re-entered for at least one cycle between bytes, so send_en pulses are at least 3 cycles apart plus the UART frame time.
- Ignore Tx_Done in IDLE and LAUNCH (stale pulse).

Decomposition:
- Shared package uart_pkg:
  - FSM state encoding (IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE).
  - BAUD_* constants (0..4 -> 9600..115200) reused by uart_byte_tx and benches.
  - Default START_TIMEOUT.
- One sub-module: rr_arbiter (combinational round-robin pick from req and last_grant, producing winner index plus a valid flag). The FSM and registers stay in uart_tx_arbiter.

Test Plan:
- Single byte: Rst 2 cycles; req[0]=1 with 8'd12, baud 4 -> ack[0] next cycle, one send_en with data_byte=12, done[0] one cycle after Tx_Done, busy drops.
- Contention: req=2'b11, data 8'd12 / 8'd55 held -> grants in order 0,1,0,1; no two consecutive acks to the same index; Rs232_Tx bytes decode to 12,55,12,55.
- Baud defer: cfg_baud_wr=1 with 3'd2 mid-frame -> baud_set stays 4 until IDLE, then 2; the next frame bit period matches index 2.
- Timeout: stub uart_state tied 0 and Tx_Done 0 -> exactly 16 cycles after send_en, err_timeout=1, FSM returns to IDLE, no done pulse, and the next req is still served.
- Reset mid-frame: assert Rst during WAIT_DONE -> next cycle all outputs at reset values, no done pulse; a new req after release is served by requester 0 first.
